// File: rtl/gfp8_pkg.sv
// Shared constants and types for the GFP8 native-vector datapath.
package gfp8_pkg;

  localparam int GROUPS      = 4;
  localparam int GROUP_SIZE  = 32;
  localparam int MAN_W       = 8;
  localparam int EXP_W       = 5;
  localparam int EXP_BIAS    = 15;
  localparam int GROUP_DOT_W = 21;
  localparam int RESULT_W    = 32;
  localparam int EXP_OUT_W   = 8;
  localparam int PROD_W      = 2 * MAN_W;
  localparam int GROUP_MAN_W = GROUP_SIZE * MAN_W;

  typedef logic signed [MAN_W-1:0]       man_t;
  typedef logic signed [GROUP_DOT_W-1:0] gdot_t;
  typedef logic signed [EXP_OUT_W-1:0]   exp_t;

  function automatic exp_t max_exp(input exp_t a, input exp_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/gfp8_group_dot.sv
// One group: exact 32-element signed int8 dot product and unbiased exponent sum.
module gfp8_group_dot
  import gfp8_pkg::*;
(
  input  logic [EXP_W-1:0]       i_exp_left,
  input  logic [EXP_W-1:0]       i_exp_right,
  input  logic [GROUP_MAN_W-1:0] i_man_left,
  input  logic [GROUP_MAN_W-1:0] i_man_right,
  output gdot_t                  o_dot,
  output exp_t                   o_exp
);

  // Sum of products; 21 bits holds 32 * (-128 * -128) without overflow.
  always_comb begin
    gdot_t                    acc;
    man_t                     a;
    man_t                     b;
    logic signed [PROD_W-1:0] a_ext;
    logic signed [PROD_W-1:0] b_ext;
    logic signed [PROD_W-1:0] prod;
    acc = '0;
    for (int i = 0; i < GROUP_SIZE; i++) begin
      a     = i_man_left[MAN_W*i +: MAN_W];
      b     = i_man_right[MAN_W*i +: MAN_W];
      a_ext = PROD_W'(a);
      b_ext = PROD_W'(b);
      prod  = a_ext * b_ext;
      acc   = acc + GROUP_DOT_W'(prod);
    end
    o_dot = acc;
  end

  // Both operands carry the bias, so the product exponent removes it twice.
  always_comb begin
    o_exp = exp_t'(i_exp_left) + exp_t'(i_exp_right) - exp_t'(2 * EXP_BIAS);
  end

endmodule

// File: rtl/gfp8_nv_dot_product.sv
// NV-level dot product: capture, per-group dot/exponent stage, align-and-sum stage.
module gfp8_nv_dot_product
  import gfp8_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_input_valid,
  input  logic [31:0]                i_exp_left,
  input  logic [GROUP_MAN_W-1:0]     i_man_left  [0:GROUPS-1],
  input  logic [31:0]                i_exp_right,
  input  logic [GROUP_MAN_W-1:0]     i_man_right [0:GROUPS-1],
  output logic signed [RESULT_W-1:0] o_result_mantissa,
  output logic signed [EXP_OUT_W-1:0] o_result_exponent
);

  logic [EXP_W-1:0]       exp_left_q  [GROUPS];
  logic [EXP_W-1:0]       exp_left_d  [GROUPS];
  logic [EXP_W-1:0]       exp_right_q [GROUPS];
  logic [EXP_W-1:0]       exp_right_d [GROUPS];
  logic [GROUP_MAN_W-1:0] man_left_q  [GROUPS];
  logic [GROUP_MAN_W-1:0] man_left_d  [GROUPS];
  logic [GROUP_MAN_W-1:0] man_right_q [GROUPS];
  logic [GROUP_MAN_W-1:0] man_right_d [GROUPS];
  logic                   cap_vld_q, cap_vld_d;

  gdot_t dot_w  [GROUPS];
  exp_t  gexp_w [GROUPS];
  gdot_t dot_q  [GROUPS];
  gdot_t dot_d  [GROUPS];
  exp_t  gexp_q [GROUPS];
  exp_t  gexp_d [GROUPS];
  logic  s1_vld_q, s1_vld_d;

  logic signed [RESULT_W-1:0]  res_man_q, res_man_d;
  exp_t                        res_exp_q, res_exp_d;

  // Capture registers load on the strobe and hold otherwise.
  always_comb begin
    cap_vld_d = i_input_valid;
    for (int g = 0; g < GROUPS; g++) begin
      exp_left_d[g]  = exp_left_q[g];
      exp_right_d[g] = exp_right_q[g];
      man_left_d[g]  = man_left_q[g];
      man_right_d[g] = man_right_q[g];
      if (i_input_valid) begin
        exp_left_d[g]  = i_exp_left[8*g +: EXP_W];
        exp_right_d[g] = i_exp_right[8*g +: EXP_W];
        man_left_d[g]  = i_man_left[g];
        man_right_d[g] = i_man_right[g];
      end
    end
  end

  for (genvar g = 0; g < GROUPS; g++) begin : g_group
    gfp8_group_dot u_group_dot (
      .i_exp_left  (exp_left_q[g]),
      .i_exp_right (exp_right_q[g]),
      .i_man_left  (man_left_q[g]),
      .i_man_right (man_right_q[g]),
      .o_dot       (dot_w[g]),
      .o_exp       (gexp_w[g])
    );
  end

  // Stage 1 only advances behind a real capture, so reset values never leak out.
  always_comb begin
    s1_vld_d = cap_vld_q;
    for (int g = 0; g < GROUPS; g++) begin
      dot_d[g]  = cap_vld_q ? dot_w[g]  : dot_q[g];
      gexp_d[g] = cap_vld_q ? gexp_w[g] : gexp_q[g];
    end
  end

  // Align every group to the largest exponent and accumulate.
  always_comb begin
    exp_t                       e_max;
    exp_t                       diff;
    logic signed [RESULT_W-1:0] ext;
    logic signed [RESULT_W-1:0] acc;
    e_max = gexp_q[0];
    for (int g = 1; g < GROUPS; g++) begin
      e_max = max_exp(e_max, gexp_q[g]);
    end
    acc = '0;
    for (int g = 0; g < GROUPS; g++) begin
      diff = e_max - gexp_q[g];
      ext  = RESULT_W'(dot_q[g]);
      if (diff >= exp_t'(31)) begin
        ext = {RESULT_W{ext[RESULT_W-1]}};
      end else begin
        ext = ext >>> diff[4:0];
      end
      acc = acc + ext;
    end
    res_man_d = s1_vld_q ? acc   : res_man_q;
    res_exp_d = s1_vld_q ? e_max : res_exp_q;
  end

  // All pipeline state clears asynchronously.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      cap_vld_q <= 1'b0;
      s1_vld_q  <= 1'b0;
      res_man_q <= '0;
      res_exp_q <= '0;
      for (int g = 0; g < GROUPS; g++) begin
        exp_left_q[g]  <= '0;
        exp_right_q[g] <= '0;
        man_left_q[g]  <= '0;
        man_right_q[g] <= '0;
        dot_q[g]       <= '0;
        gexp_q[g]      <= '0;
      end
    end else begin
      cap_vld_q <= cap_vld_d;
      s1_vld_q  <= s1_vld_d;
      res_man_q <= res_man_d;
      res_exp_q <= res_exp_d;
      for (int g = 0; g < GROUPS; g++) begin
        exp_left_q[g]  <= exp_left_d[g];
        exp_right_q[g] <= exp_right_d[g];
        man_left_q[g]  <= man_left_d[g];
        man_right_q[g] <= man_right_d[g];
        dot_q[g]       <= dot_d[g];
        gexp_q[g]      <= gexp_d[g];
      end
    end
  end

  assign o_result_mantissa = res_man_q;
  assign o_result_exponent = res_exp_q;

endmodule

// File: tb/tb_gfp8_nv_dot_product.sv
// Scoreboard bench for gfp8_nv_dot_product.
module tb_gfp8_nv_dot_product;

  logic               clk;
  logic               rst;
  logic               vld;
  logic [31:0]        tb_el;
  logic [31:0]        tb_er;
  logic [255:0]       tb_ml [0:3];
  logic [255:0]       tb_mr [0:3];
  logic signed [31:0] o_man;
  logic signed [7:0]  o_exp;

  typedef struct {
    int m;
    int e;
  } exp_s;

  exp_s sb[$];
  int   n_vec;
  int   n_err;

  gfp8_nv_dot_product dut (
    .i_clk             (clk),
    .i_reset           (rst),
    .i_input_valid     (vld),
    .i_exp_left        (tb_el),
    .i_man_left        (tb_ml),
    .i_exp_right       (tb_er),
    .i_man_right       (tb_mr),
    .o_result_mantissa (o_man),
    .o_result_exponent (o_exp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic fill(input int e, input int ml, input int mr);
    for (int g = 0; g < 4; g++) begin
      tb_el[8*g +: 8] = 8'(e);
      tb_er[8*g +: 8] = 8'(e);
      for (int i = 0; i < 32; i++) begin
        tb_ml[g][8*i +: 8] = 8'(ml);
        tb_mr[g][8*i +: 8] = 8'(mr);
      end
    end
  endtask

  task automatic model(output int m, output int e);
    int dot [4];
    int eg  [4];
    int emax;
    int d;
    for (int g = 0; g < 4; g++) begin
      dot[g] = 0;
      for (int i = 0; i < 32; i++) begin
        dot[g] += int'($signed(tb_ml[g][8*i +: 8])) * int'($signed(tb_mr[g][8*i +: 8]));
      end
      eg[g] = int'(tb_el[8*g +: 5]) + int'(tb_er[8*g +: 5]) - 30;
    end
    emax = eg[0];
    for (int g = 1; g < 4; g++) if (eg[g] > emax) emax = eg[g];
    m = 0;
    for (int g = 0; g < 4; g++) begin
      d = emax - eg[g];
      if (d >= 31) m += (dot[g] < 0) ? -1 : 0;
      else         m += dot[g] >>> d;
    end
    e = emax;
  endtask

  // Drives the current operands with valid for the next edge and records the expectation.
  task automatic drive_vec();
    exp_s x;
    model(x.m, x.e);
    sb.push_back(x);
    vld = 1'b1;
  endtask

  // Single capture; returns #1 after the edge where its result is registered.
  task automatic run_one();
    @(negedge clk);
    drive_vec();
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    vld = 1'b0;
    fill(0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (o_man !== 32'sd0) begin
      n_err++;
      $display("FAIL reset_mantissa: got %0d want 0", o_man);
    end
    n_vec++;
    if (o_exp !== 8'sd0) begin
      n_err++;
      $display("FAIL reset_exponent: got %0d want 0", o_exp);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if (o_exp !== 8'sd0 || o_man !== 32'sd0) begin
      n_err++;
      $display("FAIL idle_after_reset: got man=%0d exp=%0d want 0/0", o_man, o_exp);
    end
  endtask

  task automatic test_basic(input string name, input int e, input int ml, input int mr);
    exp_s x;
    fill(e, ml, mr);
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== 32'(x.m) || o_exp !== 8'(x.e)) begin
      n_err++;
      $display("FAIL %s: got man=%0d exp=%0d want man=%0d exp=%0d", name, o_man, o_exp, x.m, x.e);
    end
  endtask

  task automatic test_ones_hold();
    exp_s x;
    fill(15, 1, 1);
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== 32'sd128 || o_exp !== 8'sd0 || x.m != 128 || x.e != 0) begin
      n_err++;
      $display("FAIL ones: got man=%0d exp=%0d want man=128 exp=0", o_man, o_exp);
    end
    fill(3, 5, 7);
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (o_man !== 32'sd128 || o_exp !== 8'sd0) begin
      n_err++;
      $display("FAIL hold: got man=%0d exp=%0d want man=128 exp=0", o_man, o_exp);
    end
  endtask

  task automatic test_mixed_exp();
    exp_s x;
    fill(15, 1, 1);
    tb_el[15:8]  = 8'd16; tb_er[15:8]  = 8'd16;
    tb_el[23:16] = 8'd14; tb_er[23:16] = 8'd14;
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== 32'sd50 || o_exp !== 8'sd2 || x.m != 50) begin
      n_err++;
      $display("FAIL mixed_exp: got man=%0d exp=%0d want man=50 exp=2", o_man, o_exp);
    end
  endtask

  task automatic test_extremes();
    exp_s x;
    fill(15, 0, 0);
    for (int i = 0; i < 32; i++) begin
      tb_ml[0][8*i +: 8] = 8'h80;
      tb_mr[0][8*i +: 8] = 8'h80;
    end
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== 32'sd524288 || o_exp !== 8'sd0 || x.m != 524288) begin
      n_err++;
      $display("FAIL neg_times_neg: got man=%0d exp=%0d want man=524288 exp=0", o_man, o_exp);
    end
    for (int i = 0; i < 32; i++) tb_mr[0][8*i +: 8] = 8'h7f;
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== -32'sd520192 || o_exp !== 8'sd0 || x.m != -520192) begin
      n_err++;
      $display("FAIL neg_times_pos: got man=%0d exp=%0d want man=-520192 exp=0", o_man, o_exp);
    end
  endtask

  task automatic test_large_diff();
    exp_s x;
    fill(0, 0, 0);
    tb_el[7:0] = 8'd31; tb_er[7:0] = 8'd31;
    for (int i = 0; i < 32; i++) begin
      tb_ml[0][8*i +: 8] = 8'd1;
      tb_mr[0][8*i +: 8] = 8'd1;
      tb_ml[1][8*i +: 8] = 8'hff;
      tb_mr[1][8*i +: 8] = 8'd1;
    end
    run_one();
    x = sb.pop_front();
    n_vec++;
    if (o_man !== 32'sd31 || o_exp !== 8'sd32 || x.m != 31) begin
      n_err++;
      $display("FAIL large_diff: got man=%0d exp=%0d want man=31 exp=32", o_man, o_exp);
    end
  endtask

  task automatic test_mid_reset();
    fill(15, 1, 1);
    @(negedge clk);
    drive_vec();
    void'(sb.pop_back());
    @(posedge clk);
    @(negedge clk);
    vld = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_vec++;
    if (o_man !== 32'sd0 || o_exp !== 8'sd0) begin
      n_err++;
      $display("FAIL mid_reset: got man=%0d exp=%0d want 0/0", o_man, o_exp);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_vec++;
    if (o_man !== 32'sd0 || o_exp !== 8'sd0) begin
      n_err++;
      $display("FAIL after_mid_reset: got man=%0d exp=%0d want 0/0", o_man, o_exp);
    end
  endtask

  task automatic test_back_to_back();
    exp_s x;
    int   n = 24;
    for (int k = 0; k < n + 3; k++) begin
      @(negedge clk);
      if (k >= 3) begin
        x = sb.pop_front();
        n_vec++;
        if (o_man !== 32'(x.m) || o_exp !== 8'(x.e)) begin
          n_err++;
          $display("FAIL back_to_back[%0d]: got man=%0d exp=%0d want man=%0d exp=%0d",
                   k - 3, o_man, o_exp, x.m, x.e);
        end
      end
      if (k < n) begin
        for (int g = 0; g < 4; g++) begin
          tb_el[8*g +: 8] = 8'($urandom_range(0, 31));
          tb_er[8*g +: 8] = 8'($urandom_range(0, 31));
          for (int w = 0; w < 8; w++) begin
            tb_ml[g][32*w +: 32] = $urandom;
            tb_mr[g][32*w +: 32] = $urandom;
          end
        end
        if (k == 5) fill(0, 0, 0);
        drive_vec();
      end else begin
        vld = 1'b0;
      end
    end
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left want 0", sb.size());
    end
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    test_reset();
    test_ones_hold();
    test_basic("zero_mantissas", 15, 0, 0);
    test_mixed_exp();
    test_extremes();
    test_large_diff();
    test_mid_reset();
    test_basic("after_reset_capture", 15, 2, -3);
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
